// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift_sched serializer slice.
//   - FSM state encodings (ST_IDLE, ST_SHIFT)
//   - shift direction encodings (DIR_MSB_FIRST, DIR_LSB_FIRST)
//   - default word / counter widths
//   - even_parity(): parity bit that makes the total count of ones even
package shift_sched_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT = 5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  function automatic logic even_parity(input logic [WIDTH_DEFAULT-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit last-served pointer.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_en          grant enable; no grant and no pointer update when low
//   i_req[1:0]    request levels
//   o_gnt[1:0]    one-hot grant (combinational, same cycle as request)
// The pointer resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    o_gnt = 2'b00;
    ptr_d = ptr_q;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        // Both requesting: the one not served last wins.
        2'b11:   o_gnt = ptr_q ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
      if (o_gnt[0]) begin
        ptr_d = 1'b0;
      end else if (o_gnt[1]) begin
        ptr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shift_reg.sv
// Parallel-load shift register.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset (clears to 0)
//   i_load        load i_data this edge (takes priority over shifting)
//   i_dir         0 = shift left (toward MSB), 1 = shift right (toward LSB)
//   i_data        parallel load word
//   o_out         register contents
// Shifts on every edge without a load; zeros are shifted in.
module shift_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (i_load) begin
      sr_d = i_data;
    end else if (i_dir) begin
      sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end else begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o_out = sr_q;

endmodule

// File: rtl/shift_sched.sv
// Two-requester round-robin scheduler and serializer controller. Grants the
// shared shift register to one client at a time, loads its word and shifts it
// out as a framed serial stream.
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_req0/1                 word request levels
//   i_data0/1, i_dir0/1      word and bit order (0 = MSB first, 1 = LSB first)
//   o_gnt0/1                 one-cycle grant; data/dir captured on this edge
//   o_sdata, o_svalid        serial bit and its valid
//   o_sfirst, o_slast        frame delimiters
//   o_src                    requester owning the current frame
//   o_busy                   frame in progress
// Build option: define SHIFT_SCHED_PARITY_EN to append an even-parity bit,
// making frames WIDTH+1 bits long with o_slast on the parity bit.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic [WIDTH-1:0] i_data0,
  input  logic             i_dir0,
  output logic             o_gnt0,
  input  logic             i_req1,
  input  logic [WIDTH-1:0] i_data1,
  input  logic             i_dir1,
  output logic             o_gnt1,
  output logic             o_sdata,
  output logic             o_svalid,
  output logic             o_sfirst,
  output logic             o_slast,
  output logic             o_src,
  output logic             o_busy
);

`ifdef SHIFT_SCHED_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             src_q, src_d;
`ifdef SHIFT_SCHED_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             in_shift;
  logic             arb_en;
  logic [1:0]       arb_gnt;
  logic             sr_load;
  logic [WIDTH-1:0] sr_data;
  logic [WIDTH-1:0] sr_out;
  logic             unused_sr_mid;

  assign in_shift = (state_q == ST_SHIFT);

  // Grant window: idle, or the last bit of the current frame so the next
  // frame can follow with no gap. Reset closes the window combinationally.
  assign arb_en = !i_rst && (!in_shift || (cnt_q == LAST_IDX));

  rr_arb2 u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (arb_en),
    .i_req ({i_req1, i_req0}),
    .o_gnt (arb_gnt)
  );

  assign o_gnt0  = arb_gnt[0];
  assign o_gnt1  = arb_gnt[1];
  assign sr_load = |arb_gnt;
  assign sr_data = arb_gnt[1] ? i_data1 : i_data0;

  shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (sr_load),
    .i_dir  (dir_q),
    .i_data (sr_data),
    .o_out  (sr_out)
  );

  // Only the two end bits of the register are ever tapped.
  assign unused_sr_mid = ^sr_out[WIDTH-2:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    src_d   = src_q;
`ifdef SHIFT_SCHED_PARITY_EN
    parity_d = parity_q;
`endif
    if (sr_load) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      dir_d   = arb_gnt[1] ? i_dir1 : i_dir0;
      src_d   = arb_gnt[1];
`ifdef SHIFT_SCHED_PARITY_EN
      parity_d = even_parity(sr_data);
`endif
    end else if (in_shift) begin
      if (cnt_q == LAST_IDX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_MSB_FIRST;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      src_q   <= src_d;
    end
  end

`ifdef SHIFT_SCHED_PARITY_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    o_busy   = in_shift;
    o_svalid = in_shift;
    o_sfirst = in_shift && (cnt_q == '0);
    o_slast  = in_shift && (cnt_q == LAST_IDX);
    o_sdata  = 1'b0;
    if (in_shift) begin
      o_sdata = (dir_q == DIR_LSB_FIRST) ? sr_out[0] : sr_out[WIDTH-1];
`ifdef SHIFT_SCHED_PARITY_EN
      // Register content past bit WIDTH-1 is stale; emit the stored parity.
      if (cnt_q == CNT_W'(WIDTH)) begin
        o_sdata = parity_q;
      end
`endif
    end
  end

  assign o_src = src_q;

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed scenarios followed by random
// request traffic. A frame-level reference model predicts grants and pushes
// each expected frame's bits into a queue; a separate monitor pops and
// compares them whenever the design presents a valid bit.
module tb_shift_sched;

  localparam int WIDTH = 16;
`ifdef SHIFT_SCHED_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic             dir0 = 1'b0, dir1 = 1'b0;
  logic             gnt0, gnt1, sdata, svalid, sfirst, slast, src, busy;

  shift_sched dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req0   (req0),
    .i_data0  (data0),
    .i_dir0   (dir0),
    .o_gnt0   (gnt0),
    .i_req1   (req1),
    .i_data1  (data1),
    .i_dir1   (dir1),
    .o_gnt1   (gnt1),
    .o_sdata  (sdata),
    .o_svalid (svalid),
    .o_sfirst (sfirst),
    .o_slast  (slast),
    .o_src    (src),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic first;
    logic last;
    logic src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   remaining = 0;      // bits of the current frame still to appear
  logic last_served = 1'b1;
  logic granted0 = 1'b0, granted1 = 1'b0;
  logic hold = 1'b0;        // keep requests high after a grant

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of arbitration and timing.
  always @(negedge clk) begin
    logic             win;
    logic             eg0, eg1;
    logic [WIDTH-1:0] d;
    logic             dr;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (rst) begin
      chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("rst_outs", {26'd0, sdata, svalid, sfirst, slast, src, busy}, 32'd0);
      remaining   = 0;
      last_served = 1'b1;
      exp_q.delete();
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, remaining > 0});
      chk("svalid", {31'd0, svalid}, {31'd0, remaining > 0});
      if (remaining <= 1 && (req0 || req1)) begin
        win = (req0 && req1) ? ~last_served : req1;
        d   = win ? data1 : data0;
        dr  = win ? dir1 : dir0;
        eg0 = ~win;
        eg1 = win;
        for (int i = 0; i < FRAME; i++) begin
          exp_t e;
          if (i == WIDTH) e.b = ^d;
          else e.b = dr ? d[i] : d[WIDTH-1-i];
          e.first = (i == 0);
          e.last  = (i == FRAME - 1);
          e.src   = win;
          exp_q.push_back(e);
        end
        last_served = win;
        remaining   = FRAME;
      end else if (remaining > 0) begin
        remaining--;
      end
      chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
      chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
    end
    granted0 = eg0;
    granted1 = eg1;
  end

  // Monitor: compares every presented bit against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (svalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: got valid bit with empty queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sdata", {31'd0, sdata}, {31'd0, e.b});
          chk("sfirst", {31'd0, sfirst}, {31'd0, e.first});
          chk("slast", {31'd0, slast}, {31'd0, e.last});
          chk("src", {31'd0, src}, {31'd0, e.src});
        end
      end else begin
        chk("idle_zero", {29'd0, sdata, sfirst, slast}, 32'd0);
      end
    end
  end

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  // A served requester drops its request and scrambles its inputs so any
  // late capture of the input word would show up as a data error.
  task automatic step();
    @(posedge clk);
    #1;
    if (!hold) begin
      if (granted0) begin
        req0  = 1'b0;
        data0 = 16'($urandom);
        dir0  = 1'($urandom);
      end
      if (granted1) begin
        req1  = 1'b0;
        data1 = 16'($urandom);
        dir1  = 1'($urandom);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    steps(3);
    rst = 1'b0;
    steps(2);

    // Single word, MSB first then LSB first.
    req0 = 1'b1; data0 = 16'hA5C3; dir0 = 1'b0;
    steps(FRAME + 4);
    req0 = 1'b1; data0 = 16'hA5C3; dir0 = 1'b1;
    steps(FRAME + 4);

    // Both held: alternating zero-gap frames.
    hold = 1'b1;
    req0 = 1'b1; data0 = 16'h1234; dir0 = 1'b0;
    req1 = 1'b1; data1 = 16'hF00D; dir1 = 1'b1;
    steps(4 * FRAME + 2);
    req0 = 1'b0; req1 = 1'b0;
    hold = 1'b0;
    steps(FRAME + 4);

    // Late request from requester 1 waits for the last bit.
    req0 = 1'b1; data0 = 16'h8001; dir0 = 1'b0;
    steps(5);
    req1 = 1'b1; data1 = 16'h7FFE; dir1 = 1'b0;
    steps(2 * FRAME + 4);

    // Reset at bit 7 of a frame, then contention after release.
    req0 = 1'b1; data0 = 16'hC0DE; dir0 = 1'b0;
    steps(8);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {25'd0, gnt0, gnt1, sdata, svalid, sfirst, slast, src, busy}, 32'd0);
    hold = 1'b1;
    req0 = 1'b1; data0 = 16'h0F0F; dir0 = 1'b1;
    req1 = 1'b1; data1 = 16'h3C3C; dir1 = 1'b0;
    steps(2);
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    hold = 1'b0;
    steps(2 * FRAME + 4);

`ifdef SHIFT_SCHED_PARITY_EN
    req0 = 1'b1; data0 = 16'h0001; dir0 = 1'b0;
    steps(FRAME + 4);
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!req0 && $urandom_range(0, 5) == 0) begin
        req0  = 1'b1;
        data0 = 16'($urandom);
        dir0  = 1'($urandom);
      end
      if (!req1 && $urandom_range(0, 5) == 0) begin
        req1  = 1'b1;
        data1 = 16'($urandom);
        dir1  = 1'($urandom);
      end
    end

    // Drain and confirm every predicted bit appeared.
    steps(3 * FRAME);
    req0 = 1'b0;
    req1 = 1'b0;
    steps(3 * FRAME);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
